// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one combinational FP multiplier among
// N_REQ requesters, with registered results and completion/error counters.
module fp_mul_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_flag,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic [WIDTH-1:0]       mul_out,
    input  logic                   mul_flag,
    output logic                   busy,
    output logic [CNT_W-1:0]       op_count,
    output logic [CNT_W-1:0]       err_count
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Handshakes: a transfer happens on an edge where valid and ready are both
    // high for the same requester; ready never depends on anything but state
    // and req_valid, and responses are held until rsp_ready[gnt_idx] is seen.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic             grant_found;
    logic [IDX_W-1:0] grant_idx;
    logic [IDX_W-1:0] next_ptr;
    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // First valid requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_ptr) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        next_ptr = '0;
        if (int'(grant_idx) != N_REQ - 1) begin
            next_ptr = grant_idx + IDX_W'(1);
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[gnt_idx] = 1'b1;
        end
    end

    assign mul_a = op_a;
    assign mul_b = op_b;
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_idx   <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            op_count  <= '0;
            err_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        op_a    <= req_a[grant_idx*WIDTH +: WIDTH];
                        op_b    <= req_b[grant_idx*WIDTH +: WIDTH];
                        gnt_idx <= grant_idx;
                        rr_ptr  <= next_ptr;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    rsp_data <= mul_out;
                    rsp_flag <= mul_flag;
                    state    <= RESP;
                end
                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        op_count <= op_count + CNT_W'(1);
                        if (rsp_flag && (err_count != {CNT_W{1'b1}})) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
